// File: rtl/ultrasonic_multich_order_ctrl.sv
// Multi-channel ultrasonic order/DAC controller. A two-stage pipeline registers each
// command and then applies it to the addressed channel's order, image and DAC state.
module ultrasonic_multich_order_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CH         = 4,
  parameter int MAX_ORDERS     = 5,
  parameter int IMGS_PER_ORDER = 50,
  parameter int DAC_WIDTH      = 12,
  parameter int AMT_SHIFT      = 4,
  parameter int SATURATE       = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          received_data,
  input  logic [$clog2(NUM_CH)-1:0]      cmd_ch,
  output logic [NUM_CH*DAC_WIDTH-1:0]    outputDAC,
  output logic [NUM_CH-1:0]              no_order,
  output logic [NUM_CH-1:0]              order_full,
  output logic                           order_accept,
  output logic                           order_reject,
  output logic [NUM_CH-1:0]              order_done
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int OCW = $clog2(MAX_ORDERS + 1);
  localparam int ICW = (IMGS_PER_ORDER > 1) ? $clog2(IMGS_PER_ORDER) : 1;
  localparam logic [OCW-1:0] ORD_MAX  = OCW'(MAX_ORDERS);
  localparam logic [ICW-1:0] IMG_LAST = ICW'(IMGS_PER_ORDER - 1);

  // Step is evaluated one bit wider than the DAC so the carry/borrow selects the clamp.
  function automatic logic [DAC_WIDTH-1:0] dac_step(input logic [DAC_WIDTH-1:0] lvl,
                                                    input logic [7:0] amt,
                                                    input logic up);
    logic [DAC_WIDTH:0] step;
    logic [DAC_WIDTH:0] res;
    step = (DAC_WIDTH+1)'({24'd0, amt} << AMT_SHIFT);
    if (up) res = {1'b0, lvl} + step;
    else    res = {1'b0, lvl} - step;
    if ((SATURATE != 0) && res[DAC_WIDTH]) dac_step = up ? {DAC_WIDTH{1'b1}} : {DAC_WIDTH{1'b0}};
    else                                   dac_step = res[DAC_WIDTH-1:0];
  endfunction

  logic                 unused_hi_s;
  logic [14:0]          d_r;
  logic [CHW-1:0]       ch_r;
  logic [OCW-1:0]       order_cnt_r [NUM_CH];
  logic [ICW-1:0]       img_cnt_r   [NUM_CH];
  logic [DAC_WIDTH-1:0] dac_r       [NUM_CH];
  logic [OCW-1:0]       order_nxt_s [NUM_CH];
  logic [ICW-1:0]       img_nxt_s   [NUM_CH];
  logic [DAC_WIDTH-1:0] dac_nxt_s   [NUM_CH];
  logic [NUM_CH-1:0]    sel_s, clr_s, acc_s, rej_s, rcv_go_s, fin_s;
  logic                 ok_s, on_s, off_s, inc_s, dec_s, rcv_s, snd_s, vld_s;
  logic [7:0]           amt_s;

  assign unused_hi_s = ^received_data;
  assign on_s  = d_r[0];
  assign off_s = d_r[1];
  assign inc_s = d_r[2];
  assign dec_s = d_r[3];
  assign rcv_s = d_r[4];
  assign snd_s = d_r[5];
  assign vld_s = d_r[6];
  assign amt_s = d_r[14:7];
  assign ok_s  = vld_s & on_s & ~off_s;

  // Stage 1: capture command word and target channel
  always_ff @(posedge clk) begin
    if (rst_n) begin
      d_r  <= 15'd0;
      ch_r <= {CHW{1'b0}};
    end else begin
      d_r  <= received_data[14:0];
      ch_r <= cmd_ch;
    end
  end

  // Per-channel command qualification; an out-of-range ch_r matches no channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel_s[c]    = ({1'b0, ch_r} == (CHW+1)'(c));
    assign clr_s[c]    = sel_s[c] & vld_s & off_s;
    assign acc_s[c]    = sel_s[c] & ok_s & snd_s & (inc_s ^ dec_s) & (order_cnt_r[c] != ORD_MAX);
    assign rej_s[c]    = sel_s[c] & ok_s & snd_s &
                         ((inc_s & dec_s) | ((inc_s ^ dec_s) & (order_cnt_r[c] == ORD_MAX)));
    assign rcv_go_s[c] = sel_s[c] & ok_s & rcv_s & ~(inc_s & dec_s) & (order_cnt_r[c] != {OCW{1'b0}});
    assign fin_s[c]    = rcv_go_s[c] & (img_cnt_r[c] == IMG_LAST);
  end

  // Next-state for every channel; unaddressed channels hold
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      order_nxt_s[c] = order_cnt_r[c];
      img_nxt_s[c]   = img_cnt_r[c];
      dac_nxt_s[c]   = dac_r[c];
      if (clr_s[c]) begin
        order_nxt_s[c] = {OCW{1'b0}};
        img_nxt_s[c]   = {ICW{1'b0}};
        dac_nxt_s[c]   = {DAC_WIDTH{1'b0}};
      end else begin
        order_nxt_s[c] = order_cnt_r[c] + OCW'(acc_s[c]) - OCW'(fin_s[c]);
        dac_nxt_s[c]   = acc_s[c] ? dac_step(dac_r[c], amt_s, inc_s) : dac_r[c];
        if (fin_s[c])         img_nxt_s[c] = {ICW{1'b0}};
        else if (rcv_go_s[c]) img_nxt_s[c] = img_cnt_r[c] + ICW'(1);
        else                  img_nxt_s[c] = img_cnt_r[c];
      end
    end
  end

  // Stage 2: channel state and registered strobes
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        order_cnt_r[c] <= {OCW{1'b0}};
        img_cnt_r[c]   <= {ICW{1'b0}};
        dac_r[c]       <= {DAC_WIDTH{1'b0}};
      end
      order_accept <= 1'b0;
      order_reject <= 1'b0;
      order_done   <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        order_cnt_r[c] <= order_nxt_s[c];
        img_cnt_r[c]   <= img_nxt_s[c];
        dac_r[c]       <= dac_nxt_s[c];
      end
      order_accept <= |acc_s;
      order_reject <= |rej_s;
      order_done   <= fin_s;
    end
  end

  // Flatten DAC levels and derive occupancy flags
  always_comb begin
    outputDAC  = {(NUM_CH*DAC_WIDTH){1'b0}};
    no_order   = {NUM_CH{1'b0}};
    order_full = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      outputDAC[c*DAC_WIDTH +: DAC_WIDTH] = dac_r[c];
      no_order[c]   = (order_cnt_r[c] == {OCW{1'b0}});
      order_full[c] = (order_cnt_r[c] == ORD_MAX);
    end
  end

endmodule

// File: tb/tb_ultrasonic_multich_order_ctrl.sv
// Directed bench for ultrasonic_multich_order_ctrl (default parameters, SATURATE=1).
module tb_ultrasonic_multich_order_ctrl;

  localparam logic [15:0] ON  = 16'h0001;
  localparam logic [15:0] OFF = 16'h0002;
  localparam logic [15:0] INC = 16'h0004;
  localparam logic [15:0] DEC = 16'h0008;
  localparam logic [15:0] RCV = 16'h0010;
  localparam logic [15:0] SND = 16'h0020;
  localparam logic [15:0] VLD = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] received_data = 16'h0000;
  logic [1:0]  cmd_ch = 2'd0;
  logic [47:0] outputDAC;
  logic [3:0]  no_order, order_full, order_done;
  logic        order_accept, order_reject;
  int          n_cmp = 0;
  int          n_err = 0;

  ultrasonic_multich_order_ctrl dut (
    .clk(clk), .rst_n(rst_n), .received_data(received_data), .cmd_ch(cmd_ch),
    .outputDAC(outputDAC), .no_order(no_order), .order_full(order_full),
    .order_accept(order_accept), .order_reject(order_reject), .order_done(order_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] amt(input int a);
    return 16'((a & 255) << 7);
  endfunction

  function automatic logic [47:0] pk(input logic [11:0] d0, input logic [11:0] d1,
                                     input logic [11:0] d2, input logic [11:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word for a cycle, then idle; returns on the negedge after its effects land.
  task automatic issue(input logic [15:0] w, input logic [1:0] ch);
    @(negedge clk); received_data = w; cmd_ch = ch;
    @(negedge clk); received_data = 16'h0000; cmd_ch = 2'd0;
    @(negedge clk);
  endtask

  task automatic strobes(input string tag, input logic acc, input logic rej, input logic [3:0] dn);
    chk({tag, "_acc"}, 64'(order_accept), 64'(acc));
    chk({tag, "_rej"}, 64'(order_reject), 64'(rej));
    chk({tag, "_done"}, 64'(order_done), 64'(dn));
  endtask

  initial begin
    // 1. reset and idle
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dac", 64'(outputDAC), 64'(pk(12'd0, 12'd0, 12'd0, 12'd0)));
    chk("rst_no_order", 64'(no_order), 64'(4'b1111));
    chk("rst_full", 64'(order_full), 64'(4'b0000));
    strobes("rst", 1'b0, 1'b0, 4'b0000);

    // 2. ch1 increase by 10 -> 160
    issue(ON | VLD | SND | INC | amt(10), 2'd1);
    chk("ch1_inc_dac", 64'(outputDAC), 64'(pk(12'd0, 12'd160, 12'd0, 12'd0)));
    chk("ch1_inc_no_order", 64'(no_order), 64'(4'b1101));
    strobes("ch1_inc", 1'b1, 1'b0, 4'b0000);

    // 3. ch0 saturating increases until full, then reject
    for (int i = 0; i < 6; i++) begin
      issue(ON | VLD | SND | INC | amt(255), 2'd0);
      chk($sformatf("ch0_sat_dac_%0d", i), 64'(outputDAC),
          64'(pk((i == 0) ? 12'd4080 : 12'd4095, 12'd160, 12'd0, 12'd0)));
      chk($sformatf("ch0_sat_full_%0d", i), 64'(order_full), 64'((i >= 4) ? 4'b0001 : 4'b0000));
      strobes($sformatf("ch0_sat_%0d", i), (i < 5), (i == 5), 4'b0000);
    end
    issue(ON | VLD | SND | INC | DEC | amt(3), 2'd2);
    strobes("ch2_incdec", 1'b0, 1'b1, 4'b0000);
    chk("ch2_incdec_no_order", 64'(no_order), 64'(4'b1100));
    issue(ON | VLD | SND | amt(3), 2'd2);
    strobes("ch2_hold", 1'b0, 1'b0, 4'b0000);
    issue(ON | SND | INC | amt(5), 2'd2);
    strobes("ch2_novalid", 1'b0, 1'b0, 4'b0000);
    chk("ch2_novalid_dac", 64'(outputDAC), 64'(pk(12'd4095, 12'd160, 12'd0, 12'd0)));
    issue(ON | VLD | SND | DEC | amt(20), 2'd1);
    chk("ch1_dec_clamp", 64'(outputDAC), 64'(pk(12'd4095, 12'd0, 12'd0, 12'd0)));
    strobes("ch1_dec", 1'b1, 1'b0, 4'b0000);

    // 4. ch2: one order completed by 50 receives
    issue(ON | VLD | SND | INC | amt(1), 2'd2);
    chk("ch2_order_dac", 64'(outputDAC), 64'(pk(12'd4095, 12'd0, 12'd16, 12'd0)));
    chk("ch2_order_no_order", 64'(no_order), 64'(4'b1000));
    for (int i = 0; i < 49; i++) issue(ON | VLD | RCV, 2'd2);
    strobes("ch2_rcv49", 1'b0, 1'b0, 4'b0000);
    issue(ON | VLD | RCV, 2'd2);
    strobes("ch2_rcv50", 1'b0, 1'b0, 4'b0100);
    chk("ch2_rcv50_no_order", 64'(no_order), 64'(4'b1100));
    issue(ON | VLD | RCV, 2'd2);
    strobes("ch2_rcv51", 1'b0, 1'b0, 4'b0000);

    // 5. ch3 full, combined send+receive words
    for (int i = 0; i < 5; i++) issue(ON | VLD | SND | INC, 2'd3);
    chk("ch3_full", 64'(order_full), 64'(4'b1001));
    for (int i = 0; i < 49; i++) issue(ON | VLD | RCV, 2'd3);
    issue(ON | VLD | SND | INC | RCV, 2'd3);
    strobes("ch3_rej_done", 1'b0, 1'b1, 4'b1000);
    chk("ch3_rej_done_full", 64'(order_full), 64'(4'b0001));
    for (int i = 0; i < 49; i++) issue(ON | VLD | RCV, 2'd3);
    issue(ON | VLD | SND | INC | RCV, 2'd3);
    strobes("ch3_acc_done", 1'b1, 1'b0, 4'b1000);
    chk("ch3_acc_done_full", 64'(order_full), 64'(4'b0001));
    issue(ON | VLD | SND | INC, 2'd3);
    chk("ch3_refill_full", 64'(order_full), 64'(4'b1001));

    // 6. mid-operation reset, then off on ch1 only
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    chk("mid_rst_dac", 64'(outputDAC), 64'(48'd0));
    chk("mid_rst_no_order", 64'(no_order), 64'(4'b1111));
    chk("mid_rst_full", 64'(order_full), 64'(4'b0000));
    issue(ON | VLD | SND | INC | amt(10), 2'd1);
    issue(ON | VLD | SND | INC | amt(5), 2'd2);
    chk("pre_off_dac", 64'(outputDAC), 64'(pk(12'd0, 12'd160, 12'd80, 12'd0)));
    issue(VLD | OFF | SND | INC | amt(7), 2'd1);
    chk("off_ch1_dac", 64'(outputDAC), 64'(pk(12'd0, 12'd0, 12'd80, 12'd0)));
    chk("off_ch1_no_order", 64'(no_order), 64'(4'b1011));
    strobes("off_ch1", 1'b0, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
